prio_write_support: RTL

Write-side companion to the priority-encoder readout support: accepts a stream of items during one bunch crossing, writes them to consecutive addresses of the current memory page, and at each crossing boundary reports the finished page's item count. That count and page number feed the reader's `initial_count`/`init` inputs. Sits between the upstream processing stage and the paged inter-stage memory, one instance per memory.

---
 rtl/prio_write_support_pkg.sv | 16 +
 rtl/prio_write_support_wr_slot_cntr.sv | 34 +++
 rtl/prio_write_support.sv | 87 ++++++++
 3 files changed

// File: rtl/prio_write_support_pkg.sv
// Shared widths and helpers for the paged-memory write side of the priority-encoder readout.
// The item count is fixed at 6 bits and saturates at its all-ones value.
package prio_write_support_pkg;

    localparam int MEM_SIZE_DEF   = 6;
    localparam int NPAGE_BITS_DEF = 3;
    localparam int DATA_WIDTH_DEF = 36;
    localparam int CNT_W          = 6;

    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    function automatic logic cnt_is_full(input logic [CNT_W-1:0] v);
        return (v == CNT_MAX);
    endfunction

endpackage

// File: rtl/prio_write_support_wr_slot_cntr.sv
// Saturating item counter: clear restarts the count (optionally counting the current item),
// increment stops at all-ones and reports whether the current item may be accepted.
module prio_write_support_wr_slot_cntr
    import prio_write_support_pkg::*;
(
    input  logic             clk,
    input  logic             reset,
    input  logic             i_clr,
    input  logic             i_inc,
    output logic [CNT_W-1:0] o_cnt,
    output logic             o_sat,
    output logic             o_accept
);

    logic [CNT_W-1:0] r_cnt;
    logic             w_sat;

    assign w_sat    = cnt_is_full(r_cnt);
    assign o_cnt    = r_cnt;
    assign o_sat    = w_sat;
    // A clear reopens the count, so an item arriving with it is always accepted.
    assign o_accept = i_inc && (i_clr || !w_sat);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_cnt <= '0;
        end else if (i_clr) begin
            r_cnt <= CNT_W'(i_inc);
        end else if (i_inc && !w_sat) begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

endmodule

// File: rtl/prio_write_support.sv
// Writes one crossing's items to consecutive slots of the current memory page and, on each
// start strobe, reports the closed page's item count, page number and overflow flag.
module prio_write_support
    import prio_write_support_pkg::*;
#(
    parameter int MEM_SIZE   = MEM_SIZE_DEF,
    parameter int NPAGE_BITS = NPAGE_BITS_DEF,
    parameter int DATA_WIDTH = DATA_WIDTH_DEF
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic                           start,
    input  logic [DATA_WIDTH-1:0]          din,
    input  logic                           din_valid,
    output logic                           wr_en,
    output logic [NPAGE_BITS+MEM_SIZE-1:0] wr_addr,
    output logic [DATA_WIDTH-1:0]          wr_data,
    output logic [CNT_W-1:0]               count_out,
    output logic [NPAGE_BITS-1:0]          count_page,
    output logic                           count_valid,
    output logic                           overflow
);

    logic [NPAGE_BITS-1:0] r_page;
    logic [MEM_SIZE-1:0]   r_slot;
    logic                  r_ovf;

    logic [CNT_W-1:0]      w_item_cntr;
    logic                  w_sat;
    logic                  w_accept;
    logic [NPAGE_BITS-1:0] w_next_page;
    logic [NPAGE_BITS-1:0] w_wr_page;
    logic [MEM_SIZE-1:0]   w_wr_slot;

    prio_write_support_wr_slot_cntr u_item_cntr (
        .clk      (clk),
        .reset    (reset),
        .i_clr    (start),
        .i_inc    (din_valid),
        .o_cnt    (w_item_cntr),
        .o_sat    (w_sat),
        .o_accept (w_accept)
    );

    assign w_next_page = r_page + 1'b1;
    // An item coinciding with start belongs to the page being opened, at its first slot.
    assign w_wr_page   = start ? w_next_page : r_page;
    assign w_wr_slot   = start ? '0 : r_slot;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_page      <= '0;
            r_slot      <= '0;
            r_ovf       <= 1'b0;
            wr_en       <= 1'b0;
            wr_addr     <= '0;
            wr_data     <= '0;
            count_out   <= '0;
            count_page  <= '0;
            count_valid <= 1'b0;
            overflow    <= 1'b0;
        end else begin
            wr_en       <= w_accept;
            count_valid <= start;
            if (w_accept) begin
                wr_addr <= {w_wr_page, w_wr_slot};
                wr_data <= din;
            end
            if (start) begin
                count_out  <= w_item_cntr;
                count_page <= r_page;
                overflow   <= r_ovf;
                r_page     <= w_next_page;
                r_slot     <= MEM_SIZE'(w_accept);
                r_ovf      <= 1'b0;
            end else begin
                if (w_accept) begin
                    r_slot <= r_slot + 1'b1;
                end
                if (din_valid && w_sat) begin
                    r_ovf <= 1'b1;
                end
            end
        end
    end

endmodule
